// File: rtl/key64_scan_if.sv
// key64_scan_if: key-event valid/ready channel.
// The master is the event producer (key64_scan); the slave is the consumer.
interface key64_scan_if;
  logic       ev_valid;
  logic [6:0] ev_data;
  logic       ev_ready;

  modport master (output ev_valid, output ev_data, input ev_ready);
  modport slave  (input ev_valid, input ev_data, output ev_ready);
endinterface

// File: rtl/key64_scan.sv
// key64_scan: 8x8 key-matrix scanner with two-frame debounce and an event queue.
// Optional build macro KEY64_SCAN_EVFIFO_EN: 4-entry first-word-fall-through
// event FIFO; without it a single holding register stores one event.
module key64_scan #(
  parameter int unsigned SCANDIV = 5000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  col_n,
  input  logic [7:0]  row_n,
  output logic [63:0] keys,
  key64_scan_if.master ev,
  output logic        ovf
);

  typedef enum logic {ST_DWELL, ST_CHECK} state_e;

  logic [7:0]  row_s1_q, row_s2_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  col_q;
  logic [7:0]  col_n_q;
  state_e      state_q;
  logic [2:0]  chk_col_q, chk_row_q;
  logic [7:0]  samp_q;
  logic [63:0] keys_q, raw_q;
  logic        ovf_q;

  logic        last_dwell;
  logic [5:0]  chk_idx;
  logic        new_bit;
  logic        gen;
  logic [6:0]  gen_data;

  // Dwell timing and the per-row debounce decision for the row under check.
  always_comb begin
    last_dwell = (cnt_q == 16'(SCANDIV - 1));
    cnt_d      = last_dwell ? '0 : cnt_q + 16'd1;
    chk_idx    = {chk_col_q, chk_row_q};
    new_bit    = samp_q[chk_row_q];
    gen        = (state_q == ST_CHECK) && (new_bit == raw_q[chk_idx])
                 && (new_bit != keys_q[chk_idx]);
    gen_data   = {new_bit, chk_col_q, chk_row_q};
  end

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_s1_q <= '1;
      row_s2_q <= '1;
    end else begin
      row_s1_q <= row_n;
      row_s2_q <= row_s1_q;
    end
  end

  // Column scan plus DWELL/CHECK FSM; the check of one column runs during
  // the next column's dwell so column advance is never held off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      col_q     <= '0;
      col_n_q   <= 8'hFE;
      state_q   <= ST_DWELL;
      chk_col_q <= '0;
      chk_row_q <= '0;
      samp_q    <= '0;
      keys_q    <= '0;
      raw_q     <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (last_dwell) begin
        col_q   <= col_q + 3'd1;
        col_n_q <= {col_n_q[6:0], col_n_q[7]};
      end
      case (state_q)
        ST_DWELL: begin
          if (last_dwell) begin
            samp_q    <= ~row_s2_q;
            chk_col_q <= col_q;
            chk_row_q <= '0;
            state_q   <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          raw_q[chk_idx] <= new_bit;
          if (gen) keys_q[chk_idx] <= new_bit;
          chk_row_q <= chk_row_q + 3'd1;
          if (chk_row_q == 3'd7) state_q <= ST_DWELL;
        end
        default: state_q <= ST_DWELL;
      endcase
    end
  end

  logic pop;

`ifdef KEY64_SCAN_EVFIFO_EN
  logic [6:0] fifo_q [4];
  logic [1:0] wr_q, rd_q;
  logic [2:0] fill_q;
  logic       push_ok;

  // A full FIFO still accepts a push when the head is popped the same clock.
  always_comb begin
    pop     = (fill_q != 3'd0) && ev.ev_ready;
    push_ok = gen && ((fill_q != 3'd4) || pop);
  end

  // Event FIFO storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 4; i++) fifo_q[i] <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (pop) rd_q <= rd_q + 2'd1;
      if (push_ok) begin
        fifo_q[wr_q] <= gen_data;
        wr_q         <= wr_q + 2'd1;
      end else if (gen) begin
        ovf_q <= 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   fill_q <= fill_q + 3'd1;
        2'b01:   fill_q <= fill_q - 3'd1;
        default: fill_q <= fill_q;
      endcase
    end
  end

  assign ev.ev_valid = (fill_q != 3'd0);
  assign ev.ev_data  = fifo_q[rd_q];
`else
  logic [6:0] hold_q;
  logic       valid_q;

  always_comb pop = valid_q && ev.ev_ready;

  // Single holding register; a push on the accepting clock replaces the event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (gen && (!valid_q || pop)) begin
        hold_q  <= gen_data;
        valid_q <= 1'b1;
      end else begin
        if (gen) ovf_q <= 1'b1;
        if (pop) valid_q <= 1'b0;
      end
    end
  end

  assign ev.ev_valid = valid_q;
  assign ev.ev_data  = hold_q;
`endif

  assign col_n = col_n_q;
  assign keys  = keys_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_key64_scan.sv
// tb_key64_scan: directed and randomized frames against a frame-level
// debounce/event model of the key matrix scanner.
module tb_key64_scan;

`ifdef KEY64_SCAN_EVFIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  col_n;
  logic [7:0]  row_n;
  logic [63:0] keys;
  logic        ovf;
  logic [63:0] mat = '0;

  int n_checks = 0;
  int n_pass   = 0;

  key64_scan_if evif ();

  key64_scan #(.SCANDIV(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .col_n (col_n),
    .row_n (row_n),
    .keys  (keys),
    .ev    (evif.master),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Physical matrix: a closed key pulls its row low while its column is driven low.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (!col_n[c] && mat[c*8+r]) row_n[r] = 1'b0;
  end

  // Record every accepted event.
  logic [6:0] got [$];
  always @(negedge clk)
    if (evif.ev_valid === 1'b1 && evif.ev_ready === 1'b1) got.push_back(evif.ev_data);

  // Frame-level reference model.
  logic [63:0] m_keys, m_prev;
  logic        m_ovf;
  logic [6:0]  m_q [$];

  function automatic void model_reset();
    m_keys = '0;
    m_prev = '0;
    m_ovf  = 1'b0;
    m_q.delete();
  endfunction

  function automatic void model_frame(input logic [63:0] s, input bit rdy);
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++) begin
        int i = c * 8 + r;
        if (s[i] == m_prev[i] && s[i] != m_keys[i]) begin
          m_keys[i] = s[i];
          if (rdy || m_q.size() < CAP) m_q.push_back({s[i], 3'(c), 3'(r)});
          else m_ovf = 1'b1;
        end
      end
    m_prev = s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drain_compare();
    logic [6:0] e, g;
    while (m_q.size() > 0) begin
      e = m_q.pop_front();
      chk("ev_present", 64'(got.size() > 0), 64'd1);
      if (got.size() > 0) begin
        g = got.pop_front();
        chk("ev_data", 64'(g), 64'(e));
      end
    end
    chk("no_extra_ev", 64'(got.size()), 64'd0);
  endtask

  // Entered about 10 clocks into column 0's dwell; returns at the same point
  // of the following frame.
  task automatic run_frame(input logic [63:0] m, input bit rdy);
    int k = 0;
    bit left = 0;
    mat = m;
    model_frame(m, rdy);
    while (k < 400) begin
      @(posedge clk); #1;
      k++;
      if (col_n != 8'hFE) left = 1;
      else if (left) break;
    end
    chk("frame_wait", 64'(k < 400), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("keys", keys, m_keys);
    chk("ovf", 64'(ovf), 64'(m_ovf));
    if (rdy) drain_compare();
    else chk("no_ev_while_stalled", 64'(got.size()), 64'd0);
  endtask

  logic [63:0] base, m;
  logic [63:0] col2 = 64'h0000_0000_003F_0000;

  initial begin
    evif.ev_ready = 1'b1;
    model_reset();
    #12;
    // Reset state.
    chk("rst_col_n", 64'(col_n), 64'hFE);
    chk("rst_keys", keys, 64'd0);
    chk("rst_valid", 64'(evif.ev_valid), 64'd0);
    chk("rst_data", 64'(evif.ev_data), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Column sweep, no keys: two full frames.
    for (int n = 1; n <= 256; n++) begin
      logic [7:0] e;
      @(negedge clk);
      e = ~(8'd1 << ((n / 16) % 8));
      chk("col_n", 64'(col_n), 64'(e));
      chk("idle_valid", 64'(evif.ev_valid), 64'd0);
    end
    repeat (10) @(posedge clk);
    #1;

    // Key col 3 row 5 held three frames, then released two frames.
    run_frame(64'd1 << 29, 1'b1);
    chk("k29_first", 64'(keys[29]), 64'd0);
    run_frame(64'd1 << 29, 1'b1);
    chk("k29_set", 64'(keys[29]), 64'd1);
    run_frame(64'd1 << 29, 1'b1);
    run_frame(64'd0, 1'b1);
    run_frame(64'd0, 1'b1);
    chk("k29_clr", 64'(keys[29]), 64'd0);

    // Single-frame glitch on col 0 row 0.
    run_frame(64'd1, 1'b1);
    run_frame(64'd0, 1'b1);
    run_frame(64'd0, 1'b1);
    chk("glitch_keys", keys, 64'd0);

    // Randomized frames: sparse stable pattern with slow changes and glitches.
    base = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
    for (int f = 0; f < 16; f++) begin
      if ($urandom_range(0, 2) == 0) base ^= 64'd1 << $urandom_range(0, 63);
      m = base;
      if ($urandom_range(0, 3) == 0) m ^= 64'd1 << $urandom_range(0, 63);
      run_frame(m, 1'b1);
    end
    run_frame(64'd0, 1'b1);
    run_frame(64'd0, 1'b1);
    chk("released_keys", keys, 64'd0);

    // Consumer stalled, six keys in column 2.
    evif.ev_ready = 1'b0;
    run_frame(col2, 1'b0);
    run_frame(col2, 1'b0);
    chk("stall_keys", 64'(keys[21:16]), 64'h3F);
    chk("stall_ovf", 64'(ovf), 64'd1);
    chk("stall_valid", 64'(evif.ev_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_data", 64'(evif.ev_data), 64'h50);
      @(posedge clk); #1;
    end
    evif.ev_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    drain_compare();
    chk("drained_valid", 64'(evif.ev_valid), 64'd0);

    // Asynchronous reset mid-dwell of column 5, keys held through it.
    begin
      int k = 0;
      while (k < 300 && col_n != 8'hDF) begin
        @(posedge clk); #1;
        k++;
      end
      chk("col5_wait", 64'(k < 300), 64'd1);
    end
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_col_n", 64'(col_n), 64'hFE);
    chk("arst_keys", keys, 64'd0);
    chk("arst_valid", 64'(evif.ev_valid), 64'd0);
    chk("arst_data", 64'(evif.ev_data), 64'd0);
    chk("arst_ovf", 64'(ovf), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    got.delete();
    repeat (10) @(posedge clk);
    #1;
    run_frame(col2, 1'b1);
    chk("post_rst_f1", 64'(keys[21:16]), 64'd0);
    run_frame(col2, 1'b1);
    chk("post_rst_f2", 64'(keys[21:16]), 64'h3F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key64_scan.md
KEY64_SCAN -- requirements
Module: key64_scan

Interface
REQ-001 SHALL have parameter SCANDIV, default 5000, clocks per column dwell; legal range 16..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port col_n  output  8  column drive; exactly one bit low (active column), others high.
REQ-005 SHALL have port row_n  input  8  row sense, asynchronous to clk; low = key closed.
REQ-006 SHALL have port keys  output  64  debounced key state; bit col*8+row, 1 = pressed.
REQ-007 SHALL have port ev_valid  output  1  key event available.
REQ-008 SHALL have port ev_data  output  7  event {press, col[2:0], row[2:0]}; press=1 make, 0 break.
REQ-009 SHALL have port ev_ready  input  1  consumer accepts event.
REQ-010 SHALL have port ovf  output  1  sticky event-overflow flag.

Function
REQ-011 SHALL pass row_n through a two-flop synchronizer before any use.
REQ-012 SHALL hold each column active for exactly SCANDIV clocks, then advance col 0..7, wrapping 7->0; a full frame is 8*SCANDIV clocks.
REQ-013 SHALL sample the synchronized rows (inverted, 1 = closed) on the last dwell clock of the column, before col_n changes.
REQ-014 SHALL keep a 64-bit raw-sample register; a key's debounced bit changes only when the new sample equals its raw sample from the previous frame and differs from keys.
REQ-015 SHALL, after each sample, enter CHECK state and examine rows 0..7 one per clock (8 clocks), then return to DWELL; DWELL/CHECK overlap with the next dwell count and never delay column advance.
REQ-016 SHALL, in CHECK, for each row whose debounced bit changes, update keys in the same cycle and push one event with press = new state.
REQ-017 SHALL present events with valid/ready: transfer occurs on a clock with ev_valid=1 and ev_ready=1; ev_data stable while ev_valid=1 and not accepted.
REQ-018 SHALL, when an event is generated while event storage is full, drop it, still update keys, and set ovf=1 until reset.
REQ-019 SHALL, on simultaneous push and pop with storage full, accept the push (no drop, no ovf).
REQ-020 SHALL emit events in generation order (column order, then row 0..7 within a column).
REQ-021 SHALL deassert ev_valid the clock after the last stored event is accepted when no push occurs that clock.

Reset
REQ-022 SHALL, while rst=0, force col_n=8'hFE, keys=0, raw samples=0, synchronizers=8'hFF, dwell counter=0, state=DWELL, ev_valid=0, ev_data=0, ovf=0, storage empty.
REQ-023 SHALL, on rst release mid-frame, restart at column 0 with a full SCANDIV dwell; no event is generated for keys held through reset until two frames confirm them.

Configuration
REQ-024 SHALL, with macro KEY64_SCAN_EVFIFO_EN defined, store events in a 4-entry FIFO (ev_data from head, first-word-fall-through).
REQ-025 SHALL, without KEY64_SCAN_EVFIFO_EN, store events in a single holding register (full when ev_valid=1); all other behaviour identical.

Verification
REQ-026 SHALL cover: SCANDIV=16, no keys -> col_n cycles FE,FD,FB..7F each 16 clocks, wraps to FE, ev_valid stays 0.
REQ-027 SHALL cover: key col 3 row 5 held 3 frames, ev_ready=1 -> keys[29]=1 after second frame sample, one event ev_data=7'h5D, no repeat.
REQ-028 SHALL cover: same key released and held released 2 frames -> keys[29]=0, one event ev_data=7'h1D.
REQ-029 SHALL cover: single-frame glitch on col 0 row 0 -> keys stays 0, no event.
REQ-030 SHALL cover: ev_ready=0, 6 keys pressed in col 2 -> FIFO build: 4 events 7'h50..7'h53 retained, ovf=1, keys bits 16..21 all 1; holding-register build: only 7'h50 retained, ovf=1.
REQ-031 SHALL cover: rst pulsed low mid-dwell of column 5 -> col_n=FE, keys=0, ev_valid=0, ovf=0 immediately, asynchronous to clk.
